pc_reg: RTL and testbench

Program-counter register for the 24-bit processor datapath. It holds the current instruction address and drives it to instruction memory. It is either loaded with an absolute address (jump/branch target) or incremented to the next sequential instruction. It sits between the control unit, which drives `write` and `PC_INC`, and the instruction-fetch path, which consumes `ins_out`.

---
 rtl/pc_pkg.sv | 12 +
 rtl/pc_next.sv | 38 +++
 rtl/pc_reg.sv | 50 +++++
 tb/tb_pc_reg.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared program-counter definitions for the 24-bit datapath.
// Holds the default width, reset vector, increment step and address type.
package pc_pkg;

    localparam int unsigned PC_WIDTH = 24;

    localparam logic [PC_WIDTH-1:0] PC_RESET_VEC = 24'd0;
    localparam logic [PC_WIDTH-1:0] PC_INC_STEP  = 24'd1;

    typedef logic [PC_WIDTH-1:0] pc_addr_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: priority mux of hold / load / increment / keep.
// Ports: pc_q (current PC), ins_in, write, pc_inc, hold (PC_HOLD_EN), pc_d.
module pc_next
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH    = PC_WIDTH,
    parameter logic [WIDTH-1:0] INC_STEP = WIDTH'(PC_INC_STEP)
) (
    input  logic [WIDTH-1:0] pc_q,
    input  logic [WIDTH-1:0] ins_in,
    input  logic             write,
    input  logic             pc_inc,
`ifdef PC_HOLD_EN
    input  logic             hold,
`endif
    output logic [WIDTH-1:0] pc_d
);

    logic [WIDTH-1:0] pc_inc_val;

    // Wraps naturally modulo 2^WIDTH.
    assign pc_inc_val = pc_q + INC_STEP;

    always_comb begin
        pc_d = pc_q;
`ifdef PC_HOLD_EN
        if (hold) begin
            pc_d = pc_q;
        end else
`endif
        if (write) begin
            pc_d = ins_in;
        end else if (pc_inc) begin
            pc_d = pc_inc_val;
        end
    end

endmodule

// File: rtl/pc_reg.sv
// Program-counter register: load absolute address or step to next instr.
// Ports: clk, reset (sync, active-high), write, PC_INC, ins_in, ins_out,
// hold (only when PC_HOLD_EN is defined; freezes the PC for stalls).
module pc_reg
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
    parameter logic [WIDTH-1:0] INC_STEP  = WIDTH'(PC_INC_STEP)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic             PC_INC,
`ifdef PC_HOLD_EN
    input  logic             hold,
`endif
    input  logic [WIDTH-1:0] ins_in,
    output logic [WIDTH-1:0] ins_out
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    pc_next #(
        .WIDTH    (WIDTH),
        .INC_STEP (INC_STEP)
    ) u_pc_next (
        .pc_q   (pc_q),
        .ins_in (ins_in),
        .write  (write),
        .pc_inc (PC_INC),
`ifdef PC_HOLD_EN
        .hold   (hold),
`endif
        .pc_d   (pc_d)
    );

    // Reset sits outside the mux so it overrides hold as well.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign ins_out = pc_q;

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: vector table, scoreboard queue,
// random run against a behavioural model, hold checks with PC_HOLD_EN.
`timescale 1ns/1ps
module tb_pc_reg;

    localparam int W = 24;

`ifdef PC_HOLD_EN
    localparam bit HAS_HOLD = 1'b1;
`else
    localparam bit HAS_HOLD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         write = 1'b0;
    logic         pc_inc = 1'b0;
    logic         hold = 1'b0;
    logic [W-1:0] ins_in = '0;
    logic [W-1:0] ins_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_pc;

    typedef struct {
        bit           rst;
        bit           wr;
        bit           inc;
        logic [W-1:0] din;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[18];

    always #10 clk = ~clk;

    pc_reg dut (
        .clk     (clk),
        .reset   (reset),
        .write   (write),
        .PC_INC  (pc_inc),
`ifdef PC_HOLD_EN
        .hold    (hold),
`endif
        .ins_in  (ins_in),
        .ins_out (ins_out)
    );

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d",
                 n_pass, n_checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, req);
    endtask

    // Drive on negedge, push expectation, compare #1 after the edge.
    task automatic step(input string name, input bit r, input bit w,
                        input bit inc, input bit h,
                        input logic [W-1:0] din,
                        input logic [W-1:0] exp);
        logic [W-1:0] e;
        @(negedge clk);
        reset  = r;
        write  = w;
        pc_inc = inc;
        hold   = h;
        ins_in = din;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, ins_out, 'x);
        end else begin
            e = exp_q.pop_front();
            check(name, ins_out, e);
        end
    endtask

    function automatic logic [W-1:0] model_next(
        input logic [W-1:0] pc, input bit r, input bit w,
        input bit inc, input bit h, input logic [W-1:0] din);
        if (r) return '0;
        if (HAS_HOLD && h) return pc;
        if (w) return din;
        if (inc) return pc + 24'd1;
        return pc;
    endfunction

    initial begin
        vecs[0]  = '{1, 1, 0, 24'd100,     24'd0};
        vecs[1]  = '{0, 1, 0, 24'd100,     24'd100};
        vecs[2]  = '{0, 1, 0, 24'd100,     24'd100};
        vecs[3]  = '{0, 1, 0, 24'd100,     24'd100};
        vecs[4]  = '{0, 0, 1, 24'd100,     24'd101};
        vecs[5]  = '{0, 0, 1, 24'd100,     24'd102};
        vecs[6]  = '{0, 0, 1, 24'd100,     24'd103};
        vecs[7]  = '{0, 1, 1, 24'd500,     24'd500};
        vecs[8]  = '{0, 0, 0, 24'd123,     24'd500};
        vecs[9]  = '{0, 0, 0, 24'd123,     24'd500};
        vecs[10] = '{0, 1, 0, 24'hFFFFFF,  24'hFFFFFF};
        vecs[11] = '{0, 0, 1, 24'd0,       24'h000000};
        vecs[12] = '{0, 0, 1, 24'd0,       24'h000001};
        vecs[13] = '{1, 0, 1, 24'd0,       24'h000000};
        vecs[14] = '{0, 0, 1, 24'd0,       24'h000001};
        vecs[15] = '{0, 1, 0, 24'hFFFFFE,  24'hFFFFFE};
        vecs[16] = '{0, 0, 1, 24'd0,       24'hFFFFFF};
        vecs[17] = '{0, 0, 1, 24'd0,       24'h000000};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 18; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].wr,
                 vecs[i].inc, 1'b0, vecs[i].din, vecs[i].exp);
        end

        // Held increment with a reset pulse in the middle.
        step("seq_load", 0, 1, 0, 0, 24'd40, 24'd40);
        step("seq_inc1", 0, 0, 1, 0, 24'd0, 24'd41);
        step("seq_inc2", 0, 0, 1, 0, 24'd0, 24'd42);
        step("seq_rst",  1, 0, 1, 0, 24'd0, 24'd0);
        step("seq_res1", 0, 0, 1, 0, 24'd0, 24'd1);
        step("seq_res2", 0, 0, 1, 0, 24'd0, 24'd2);

        // No combinational path: changing inputs mid-cycle has no effect.
        @(negedge clk);
        write  = 1'b1;
        pc_inc = 1'b0;
        ins_in = 24'h5A5A5A;
        #3;
        check("no_comb_path", ins_out, 24'd2);
        @(posedge clk);
        #1;
        check("no_comb_load", ins_out, 24'h5A5A5A);

`ifdef PC_HOLD_EN
        step("hold_load", 0, 1, 0, 0, 24'd200, 24'd200);
        step("hold_blk",  0, 1, 1, 1, 24'd7,   24'd200);
        step("hold_blk2", 0, 0, 1, 1, 24'd7,   24'd200);
        step("hold_rst",  1, 0, 0, 1, 24'd7,   24'd0);
        step("hold_rel",  0, 0, 1, 0, 24'd7,   24'd1);
`endif

        // Random run against the behavioural model.
        model_pc = ins_out;
        for (int i = 0; i < 60; i++) begin
            bit r, w, inc, h;
            logic [W-1:0] din;
            r   = ($urandom_range(0, 15) == 0);
            w   = $urandom_range(0, 1);
            inc = $urandom_range(0, 1);
            h   = HAS_HOLD ? ($urandom_range(0, 3) == 0) : 1'b0;
            din = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF
                                              : 24'($urandom);
            model_pc = model_next(model_pc, r, w, inc, h, din);
            step($sformatf("rnd%0d", i), r, w, inc, h, din, model_pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
